// File: rtl/csa64_pkg.sv
// Shared defaults and result type for the CSA64 operand sequencer.
package csa64_pkg;

    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_LAT   = 1;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
    } result_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count; head is visible one edge after a write.
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_wr;
    logic          do_rd;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    // Empty head reads as zero so the unreset storage never leaks out.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (!do_wr && do_rd) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/csa64_op_sequencer.sv
// Feeds operand pairs into the registered CSA64 adder and collects its results,
// issuing only against free result-buffer credits so nothing is ever dropped.
module csa64_op_sequencer
    import csa64_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned LAT    = DEF_LAT,
    parameter int unsigned IDEPTH = 4,
    parameter int unsigned RDEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_op1,
    output logic [WIDTH-1:0] add_op2,
    output logic             add_rst,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_crout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic [15:0]      done_cnt
);

    localparam int unsigned ICW = $clog2(IDEPTH + 1);
    localparam int unsigned RCW = $clog2(RDEPTH + 1);
    localparam int unsigned UW  = $clog2(RDEPTH + LAT + 2);

    logic [2*WIDTH-1:0] ififo_head;
    logic [ICW-1:0]     ififo_count;
    logic [RCW-1:0]     res_count;
    logic               ififo_full;
    logic               ififo_empty;
    logic               issue;
    logic               capture;
    logic               deq;
    logic [LAT:0]       tag;
    logic [UW-1:0]      used;
    result_t            res_in;
    result_t            res_head;

    assign add_rst     = !reset;
    assign ififo_full  = ififo_count == ICW'(IDEPTH);
    assign ififo_empty = ififo_count == '0;
    assign in_ready    = !ififo_full;
    assign capture     = tag[LAT];
    assign res_valid   = res_count != '0;
    assign deq         = res_valid && res_ready;
    assign res_in      = '{sum: add_sum, cout: add_crout};
    assign res_sum     = res_head.sum;
    assign res_cout    = res_head.cout;

    // Slots already claimed: buffered results plus every op still in the adder.
    always_comb begin
        used = UW'(res_count);
        for (int unsigned i = 0; i <= LAT; i++) begin
            used = used + UW'(tag[i]);
        end
    end

    assign issue = !ififo_empty && (used < UW'(RDEPTH));

    sync_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (IDEPTH)
    ) u_in_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (in_valid),
        .wr_data ({in_a, in_b}),
        .rd_en   (issue),
        .rd_data (ififo_head),
        .count   (ififo_count)
    );

    sync_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (RDEPTH)
    ) u_res_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (res_in),
        .rd_en   (res_ready),
        .rd_data (res_head),
        .count   (res_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            add_op1  <= '0;
            add_op2  <= '0;
            tag      <= '0;
            done_cnt <= '0;
        end else begin
            if (issue) begin
                add_op1 <= ififo_head[2*WIDTH-1:WIDTH];
                add_op2 <= ififo_head[WIDTH-1:0];
            end
            tag <= {tag[LAT-1:0], issue};
            if (deq) done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_csa64_op_sequencer.sv
// Randomized and directed bench for csa64_op_sequencer with a behavioural adder
// and an in-order result scoreboard.
module tb_csa64_op_sequencer;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned LAT    = 1;
    localparam int unsigned IDEPTH = 4;
    localparam int unsigned RDEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_op1;
    logic [WIDTH-1:0] add_op2;
    logic             add_rst;
    logic [WIDTH-1:0] add_sum;
    logic             add_crout;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic [15:0]      done_cnt;

    always #5 clock = ~clock;

    csa64_op_sequencer #(
        .WIDTH  (WIDTH),
        .LAT    (LAT),
        .IDEPTH (IDEPTH),
        .RDEPTH (RDEPTH)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_op1   (add_op1),
        .add_op2   (add_op2),
        .add_rst   (add_rst),
        .add_sum   (add_sum),
        .add_crout (add_crout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .done_cnt  (done_cnt)
    );

    // Registered adder stand-in: LAT edges from operands to sum/carry.
    logic [WIDTH:0] add_pipe [LAT];
    always @(posedge clock) begin
        for (int i = int'(LAT) - 1; i > 0; i--) begin
            add_pipe[i] <= add_rst ? '0 : add_pipe[i-1];
        end
        add_pipe[0] <= add_rst ? '0 : ({1'b0, add_op1} + {1'b0, add_op2});
    end
    assign add_sum   = add_pipe[LAT-1][WIDTH-1:0];
    assign add_crout = add_pipe[LAT-1][WIDTH];

    int             n_checks = 0;
    int             n_fails  = 0;
    logic [WIDTH:0] exp_q [$];
    logic [15:0]    done_m = '0;
    logic [WIDTH:0] mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted pair must come back, in order, as a+b.
    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            done_m = '0;
        end else begin
            check("done_cnt", 64'(done_cnt), 64'(done_m));
            if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 64'd0, 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_sum", res_sum, mon_e[WIDTH-1:0]);
                    check("res_cout", 64'(res_cout), 64'(mon_e[WIDTH]));
                end
                done_m = done_m + 16'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!res_valid && n < limit) begin
            tick();
            n++;
        end
        if (!res_valid) check("wait_res_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_res_valid", 64'(res_valid), 64'd0);
    endtask

    function automatic logic [63:0] rnd();
        int unsigned s = $urandom_range(0, 7);
        if (s == 0) return '1;
        if (s == 1) return '0;
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          k;
        int          first;
        int          last;
        int          nv;
        int          hs_cnt;
        logic        hs;
        logic [15:0] wrap_exp [3] = '{16'hFFFF, 16'h0000, 16'h0001};

        reset     = 1'b0;
        in_valid  = 1'b1;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;

        // Reset held two edges with in_valid asserted.
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_op1", add_op1, 64'd0);
        check("rst_op2", add_op2, 64'd0);
        check("rst_done", 64'(done_cnt), 64'd0);
        check("rst_add_rst", 64'(add_rst), 64'd1);
        check("rst_res_sum", res_sum, 64'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (5) tick();
        check("post_rst_res_valid", 64'(res_valid), 64'd0);
        check("post_rst_op1", add_op1, 64'd0);
        check("post_rst_add_rst", 64'(add_rst), 64'd0);

        // Single op: latency and carry-out.
        in_valid = 1'b1;
        in_a     = 64'hF20F_FFFF_FFFF_FFFF;
        in_b     = 64'hFFFF_FFFF_FFFF_FF50;
        tick();
        in_valid = 1'b0;
        wait_valid(20, n);
        check("single_latency", 64'(n), 64'(LAT + 2));
        check("single_sum", res_sum, 64'hF20F_FFFF_FFFF_FF4F);
        check("single_cout", 64'(res_cout), 64'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("single_drained", 64'(res_valid), 64'd0);

        // Streaming: pairs (i, i+1), one result per cycle.
        do_reset();
        res_ready = 1'b1;
        first = -1;
        last = -1;
        nv = 0;
        hs_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 8);
            in_a     = 64'(c);
            in_b     = 64'(c + 1);
            if (in_valid && in_ready) hs_cnt++;
            tick();
            if (res_valid) begin
                if (first < 0) first = c;
                last = c;
                nv++;
            end
        end
        in_valid = 1'b0;
        check("stream_accepted", 64'(hs_cnt), 64'd8);
        check("stream_results", 64'(nv), 64'd8);
        check("stream_contiguous", 64'(last - first), 64'd7);
        check("stream_first", 64'(first), 64'(LAT + 2));
        check("stream_done", 64'(done_cnt), 64'd8);

        // Backpressure: buffer fills, then the FIFO, then refusal.
        do_reset();
        k = 0;
        in_a = rnd();
        in_b = rnd();
        for (int c = 0; c < 30; c++) begin
            in_valid = (k < 10);
            hs = in_valid && in_ready;
            tick();
            if (hs) begin
                k++;
                in_a = rnd();
                in_b = rnd();
            end
        end
        check("bp_accepted", 64'(k), 64'(RDEPTH + IDEPTH));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_res_valid", 64'(res_valid), 64'd1);
        drain(200);
        check("bp_done", 64'(done_cnt), 64'(RDEPTH + IDEPTH));

        // Reset with ops in flight and queued.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_a     = rnd();
            in_b     = rnd();
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midrst_no_stale", 64'(res_valid), 64'd0);
        end
        in_valid = 1'b1;
        in_a     = 64'd5;
        in_b     = 64'd7;
        tick();
        in_valid = 1'b0;
        wait_valid(20, n);
        check("midrst_sum", res_sum, 64'd12);
        check("midrst_cout", 64'(res_cout), 64'd0);
        drain(50);

        // Randomized traffic with random backpressure.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 3) != 0);
            in_a      = rnd();
            in_b      = rnd();
            tick();
        end
        drain(400);

        // Run done_cnt up to 0xFFFE, then watch it wrap.
        n = 32'hFFFE - int'(done_m);
        k = 0;
        res_ready = 1'b1;
        for (int c = 0; c < n + 100 && k < n; c++) begin
            in_valid = 1'b1;
            in_a     = rnd();
            in_b     = rnd();
            hs       = in_ready;
            tick();
            if (hs) k++;
        end
        in_valid = 1'b0;
        check("wrap_pushed", 64'(k), 64'(n));
        drain(200);
        check("wrap_pre", 64'(done_cnt), 64'hFFFE);
        res_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_a     = rnd();
            in_b     = rnd();
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        for (int j = 0; j < 3; j++) begin
            check("wrap_valid", 64'(res_valid), 64'd1);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check("wrap_cnt", 64'(done_cnt), 64'(wrap_exp[j]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
